// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between a UART receiver and its consumer, with a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic          SCLK,
  input  logic          RST,
  input  logic [7:0]    wr_data,
  input  logic          wr_stb,
  input  logic          rd_en,
  input  logic          ovf_clr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow
);
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d, ovf_q, ovf_d;
  logic        rd_acc, wr_acc, drop;
  assign empty       = count_q == '0;
  assign full        = count_q == (AW+1)'(DEPTH);
  assign almost_full = count_q >= (AW+1)'(AFULL_LVL);
  assign count       = count_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign overflow    = ovf_q;
  // A full FIFO still takes a write when a pop frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_stb & (~full | rd_acc);
  assign drop   = wr_stb & full & ~rd_acc;
  always_comb begin
    wptr_d     = wr_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = rd_acc ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    rd_data_d  = rd_acc ? mem_q[rptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
    ovf_d      = drop | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge SCLK) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end
  always_ff @(posedge SCLK) begin
    if (!RST && wr_acc) mem_q[wptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a byte scoreboard checked by a separate rd_valid monitor.
module tb_uart_rx_fifo;
  logic       SCLK = 1'b0, RST = 1'b1, wr_stb = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00, rd_data;
  logic       rd_valid, empty, full, almost_full, overflow;
  logic [4:0] count;
  logic [7:0] exp_q[$];
  logic [7:0] last_pop = 8'h00;
  int tests = 0, fails = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .AFULL_LVL(12)) dut (
    .SCLK(SCLK), .RST(RST), .wr_data(wr_data), .wr_stb(wr_stb), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge SCLK) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else begin
        last_pop = exp_q.pop_front();
        chk("rd_data", int'(rd_data), int'(last_pop));
      end
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_stb = w; wr_data = d; rd_en = r; ovf_clr = c;
    @(posedge SCLK); #1;
    wr_stb = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge SCLK);
    #1 RST = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    wr(8'hA5);
    chk("empty_after_write", int'(empty), 0);
    wr(8'h3C);
    pop();
    chk("rd_valid_pulse", int'(rd_valid), 1);
    pop();
    @(posedge SCLK); #1;
    chk("rd_valid_one_cycle", int'(rd_valid), 0);
    chk("empty_after_pops", int'(empty), 1);
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      chk("afull_level", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
    end
    chk("full_at_16", int'(full), 1);
    chk("count_at_16", int'(count), 16);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_on_drop", int'(overflow), 1);
    chk("count_after_drop", int'(count), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(overflow), 0);
    exp_q.push_back(8'h77);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("count_full_rw", int'(count), 16);
    chk("ovf_full_rw", int'(overflow), 0);
    chk("full_rw_still_full", int'(full), 1);
    repeat (16) pop();
    @(posedge SCLK); #1;
    chk("empty_after_drain", int'(empty), 1);
    pop();
    chk("rd_en_empty_valid", int'(rd_valid), 0);
    chk("rd_en_empty_data", int'(rd_data), 8'h77);
    exp_q.push_back(8'h11);
    cyc(1'b1, 8'h11, 1'b1, 1'b0);
    chk("no_fallthrough_count", int'(count), 1);
    chk("no_fallthrough_valid", int'(rd_valid), 0);
    pop();
    @(posedge SCLK); #1;
    for (int i = 0; i < 40; i++) begin
      wr(8'h80 + 8'(i));
      pop();
    end
    @(posedge SCLK); #1;
    chk("wrap_empty", int'(empty), 1);
    for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i));
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_with_drop", int'(overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", int'(overflow), 0);
    repeat (16) pop();
    @(posedge SCLK); #1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    chk("count_before_rst", int'(count), 5);
    RST = 1'b1;
    @(posedge SCLK); #1;
    RST = 1'b0;
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_count", int'(count), 0);
    wr(8'h5A);
    pop();
    chk("post_rst_valid", int'(rd_valid), 1);
    @(posedge SCLK); #1;
    chk("pending_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, minimum 2.
REQ-002 SHALL have parameter AW, default 4, pointer width; equals log2(DEPTH).
REQ-003 SHALL have parameter AFULL_LVL, default 12, almost-full threshold in entries; range 1..DEPTH.
REQ-004 SHALL have port SCLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port wr_data  input  8  received byte from the UART receiver's o_RECEIVED_DATA.
REQ-007 SHALL have port wr_stb  input  1  write strobe from the receiver's receive_done; each high cycle is one write request.
REQ-008 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-009 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 SHALL have port rd_data  output  8  registered output byte.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse; rd_data holds a newly popped byte.
REQ-012 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-013 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port almost_full  output  1  count >= AFULL_LVL.
REQ-015 SHALL have port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky flag; a byte was dropped.

Function
REQ-017 SHALL store bytes in a DEPTH x 8 register array addressed by write and read pointers of width AW; both pointers wrap from DEPTH-1 to 0.
REQ-018 SHALL track occupancy in an AW+1 bit counter; full/empty/almost_full SHALL be decoded from the counter only.
REQ-019 SHALL accept a write when wr_stb=1 and (full=0 or an accepted read occurs in the same cycle): store wr_data at wptr, then wptr+1.
REQ-020 SHALL accept a read when rd_en=1 and empty=0: rd_data <= mem[rptr], then rptr+1, and rd_valid=1 on the next cycle.
REQ-021 SHALL ignore rd_en while empty=1: no pointer change, rd_valid=0, rd_data holds its previous value.
REQ-022 SHALL provide no fall-through: with empty=1, a simultaneous write and rd_en accepts the write only; count becomes 1.
REQ-023 SHALL, on a simultaneous accepted write and read with full=1, accept both and leave count at DEPTH.
REQ-024 SHALL, on wr_stb=1 with full=1 and no accepted read, drop wr_data, leave the pointers and count unchanged, and set overflow=1 on the next cycle.
REQ-025 SHALL update count as +1 for write only, -1 for read only, and unchanged for both or neither.
REQ-026 SHALL clear overflow on ovf_clr=1; if ovf_clr and a new drop occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-027 SHALL hold rd_data stable between accepted reads.
REQ-028 SHALL give write-to-empty-deassert latency of 1 cycle (empty=0 on the cycle after the accepted write) and read-to-data latency of 1 cycle.

Reset
REQ-029 SHALL, while RST=1 at a clock edge: set wptr=0, rptr=0, count=0, rd_data=8'h00, rd_valid=0, overflow=0; as a result empty=1, full=0, almost_full=0.
REQ-030 SHALL give RST priority over all requests in the same cycle; array contents need not be cleared.
REQ-031 SHALL, on reset asserted mid-operation (FIFO partially full), discard all stored bytes; the first read after reset SHALL return the first byte written after reset.

Verification
REQ-032 SHALL cover: write 8'hA5, 8'h3C, then pop twice -> rd_valid pulses, rd_data=8'hA5 then 8'h3C; empty=1 after the second pop.
REQ-033 SHALL cover: 16 writes 8'h00..8'h0F -> full=1, count=16, almost_full high from count 12; a 17th write 8'hFF -> overflow=1, count=16; 16 pops return 8'h00..8'h0F.
REQ-034 SHALL cover: with full=1, simultaneous write 8'h77 and rd_en -> oldest byte popped, count=16, overflow=0; 8'h77 is returned last.
REQ-035 SHALL cover: rd_en with empty=1 -> rd_valid=0 and rd_data unchanged; simultaneous write 8'h11 and rd_en while empty -> count=1, next pop returns 8'h11.
REQ-036 SHALL cover: 40 write/pop cycles -> pointer wrap, data order preserved; ovf_clr asserted together with a drop -> overflow stays 1; ovf_clr alone -> overflow=0.
REQ-037 SHALL cover: RST pulse with count=5 -> empty=1, count=0; a write of 8'h5A then a pop -> rd_data=8'h5A.
